// File: rtl/fp_convert_pipe_if.sv
// Streaming bus for fp_convert_pipe: a valid/ready input channel carrying a
// two's-complement sample and a valid/ready output channel carrying the
// sign / exponent / significand / saturation result.
interface fp_convert_pipe_if #(
    parameter int DW = 13,
    parameter int EW = 3,
    parameter int MW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_s;
    logic [EW-1:0] out_e;
    logic [MW-1:0] out_f;
    logic          out_sat;

    // Producer side: drives samples in, consumes results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_s, out_e, out_f, out_sat
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_s, out_e, out_f, out_sat
    );
endinterface

// File: rtl/fp_convert_pipe.sv
// fp_convert_pipe: three-stage integer -> small float converter.
//   S1: sign/magnitude (most-negative input clamps and flags saturation)
//   S2: leading-one extraction into exponent E and significand F
//   S3: optional round-to-nearest with exponent overflow saturation
// Result value = out_f * 2^out_e, sign in out_s.
// Configuration macro: FPCVT_ROUND_EN -- when defined S3 rounds using the
// first discarded bit; when undefined S3 truncates. Latency is 3 either way.
module fp_convert_pipe #(
    parameter int DW = 13,
    parameter int EW = 3,
    parameter int MW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_convert_pipe_if.slave bus
);

    // Reject parameter sets where the exponent cannot cover the input range
    generate
        if (DW < 3 || DW > 32 || MW < 2 || (DW - 1) > (MW + (1 << EW) - 1)) begin : g_bad_params
            $error("fp_convert_pipe: illegal DW/EW/MW combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic          s1_v_q;
    logic          s1_s_q;
    logic [DW-2:0] s1_m_q;
    logic          s1_sat_q;

    logic          s2_v_q;
    logic          s2_s_q;
    logic [EW-1:0] s2_e_q;
    logic [MW-1:0] s2_f_q;
    logic          s2_sat_q;
`ifdef FPCVT_ROUND_EN
    logic          s2_r_q;
    logic          s2_r_d;
`endif

    logic          s3_v_q;
    logic          s3_s_q;
    logic [EW-1:0] s3_e_q;
    logic [MW-1:0] s3_f_q;
    logic          s3_sat_q;

    // ------------------------------------------------------------------
    // Flow control: a stage loads when empty or when its content moves on
    // ------------------------------------------------------------------
    logic ld1_w;
    logic ld2_w;
    logic ld3_w;

    assign ld3_w = ~s3_v_q | bus.out_ready;
    assign ld2_w = ~s2_v_q | ld3_w;
    assign ld1_w = ~s1_v_q | ld2_w;

    // Held low during reset so nothing is accepted while the pipe is cleared
    assign bus.in_ready = rst_n & ld1_w;

    // ------------------------------------------------------------------
    // S1 combinational: magnitude on DW-1 bits
    // ------------------------------------------------------------------
    logic          s1_neg_w;
    logic          s1_most_neg_w;
    logic [DW-2:0] s1_low_w;
    logic [DW-2:0] s1_m_d;

    assign s1_neg_w      = bus.in_data[DW-1];
    assign s1_low_w      = bus.in_data[DW-2:0];
    assign s1_most_neg_w = s1_neg_w & ~(|s1_low_w);

    // The negated low bits are the exact magnitude for every negative input
    // except the most-negative one, which clamps to the largest magnitude.
    always_comb begin
        if (s1_most_neg_w)
            s1_m_d = '1;
        else if (s1_neg_w)
            s1_m_d = ~s1_low_w + (DW-1)'(1);
        else
            s1_m_d = s1_low_w;
    end

    // S1 registers: capture sign, magnitude and clamp flag on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_s_q   <= 1'b0;
            s1_m_q   <= '0;
            s1_sat_q <= 1'b0;
        end else if (ld1_w) begin
            s1_v_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_s_q   <= s1_neg_w;
                s1_m_q   <= s1_m_d;
                s1_sat_q <= s1_most_neg_w;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: leading-one position sets the shift; F is the MW
    // bits starting at the leading one, R is the next bit below.
    // ------------------------------------------------------------------
    logic [EW-1:0] s2_e_d;
    logic [MW-1:0] s2_f_d;

    // Small magnitudes (below 2^MW) give a shift of zero, so F = M directly
    always_comb begin
        int lead;
        int sh;
        lead = -1;
        for (int b = 0; b < DW-1; b++) begin
            if (s1_m_q[b]) lead = b;
        end
        sh = (lead >= MW) ? (lead - MW + 1) : 0;
        s2_e_d = EW'(sh);
        s2_f_d = '0;
        for (int j = 0; j < MW; j++) begin
            for (int b = 0; b < DW-1; b++) begin
                if (b == j + sh) s2_f_d[j] = s1_m_q[b];
            end
        end
`ifdef FPCVT_ROUND_EN
        s2_r_d = 1'b0;
        for (int b = 0; b < DW-1; b++) begin
            if (sh > 0 && b == sh - 1) s2_r_d = s1_m_q[b];
        end
`endif
    end

    // S2 registers: hold exponent/significand (and round bit) for S3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q   <= 1'b0;
            s2_s_q   <= 1'b0;
            s2_e_q   <= '0;
            s2_f_q   <= '0;
            s2_sat_q <= 1'b0;
`ifdef FPCVT_ROUND_EN
            s2_r_q   <= 1'b0;
`endif
        end else if (ld2_w) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_s_q   <= s1_s_q;
                s2_e_q   <= s2_e_d;
                s2_f_q   <= s2_f_d;
                s2_sat_q <= s1_sat_q;
`ifdef FPCVT_ROUND_EN
                s2_r_q   <= s2_r_d;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: rounding and exponent overflow saturation
    // ------------------------------------------------------------------
    logic [EW-1:0] s3_e_d;
    logic [MW-1:0] s3_f_d;
    logic          s3_sat_d;
`ifdef FPCVT_ROUND_EN
    logic [MW:0]   s3_f_inc_w;
    logic [EW:0]   s3_e_inc_w;

    assign s3_f_inc_w = {1'b0, s2_f_q} + (MW+1)'(1);
    assign s3_e_inc_w = {1'b0, s2_e_q} + (EW+1)'(1);
`endif

    // A significand carry renormalises to 1.000.. and bumps the exponent;
    // an exponent carry clamps both fields to all-ones.
    always_comb begin
        s3_e_d   = s2_e_q;
        s3_f_d   = s2_f_q;
        s3_sat_d = s2_sat_q;
`ifdef FPCVT_ROUND_EN
        if (s2_r_q) begin
            if (s3_f_inc_w[MW]) begin
                if (s3_e_inc_w[EW]) begin
                    s3_e_d   = '1;
                    s3_f_d   = '1;
                    s3_sat_d = 1'b1;
                end else begin
                    s3_e_d = s3_e_inc_w[EW-1:0];
                    s3_f_d = {1'b1, {(MW-1){1'b0}}};
                end
            end else begin
                s3_f_d = s3_f_inc_w[MW-1:0];
            end
        end
`endif
    end

    // S3 registers double as the output registers; they hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v_q   <= 1'b0;
            s3_s_q   <= 1'b0;
            s3_e_q   <= '0;
            s3_f_q   <= '0;
            s3_sat_q <= 1'b0;
        end else if (ld3_w) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_s_q   <= s2_s_q;
                s3_e_q   <= s3_e_d;
                s3_f_q   <= s3_f_d;
                s3_sat_q <= s3_sat_d;
            end
        end
    end

    assign bus.out_valid = s3_v_q;
    assign bus.out_s     = s3_s_q;
    assign bus.out_e     = s3_e_q;
    assign bus.out_f     = s3_f_q;
    assign bus.out_sat   = s3_sat_q;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Bench for fp_convert_pipe at default parameters: directed vector table,
// stall and mid-stream reset sequences, then a full input sweep against an
// arithmetic reference model with random output back-pressure.
module tb_fp_convert_pipe;
    localparam int DW = 13;
    localparam int EW = 3;
    localparam int MW = 5;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
        logic          sat;
    } res_t;

    typedef struct {
        logic [DW-1:0] din;
        res_t          r;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_convert_pipe_if #(.DW(DW), .EW(EW), .MW(MW)) bus ();

    fp_convert_pipe #(.DW(DW), .EW(EW), .MW(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    function automatic res_t mk(input logic s, input int e, input int f, input logic sat);
        res_t o;
        o.s = s; o.e = EW'(e); o.f = MW'(f); o.sat = sat;
        return o;
    endfunction

    // Arithmetic reference: divide the magnitude down until it fits MW bits
    function automatic res_t model(input logic [DW-1:0] x);
        int   v, m, e, f;
        logic sat;
        res_t o;
        v   = int'($signed(x));
        sat = 1'b0;
        if (v == -4096) begin m = 4095; sat = 1'b1; end
        else m = (v < 0) ? -v : v;
        e = 0;
        while ((m >> e) >= 32) e++;
        f = m >> e;
`ifdef FPCVT_ROUND_EN
        if (e > 0 && ((m >> (e - 1)) & 1) == 1) begin
            f = f + 1;
            if (f == 32) begin f = 16; e = e + 1; end
        end
        if (e > 7) begin e = 7; f = 31; sat = 1'b1; end
`endif
        o.s = x[DW-1]; o.e = EW'(e); o.f = MW'(f); o.sat = sat;
        return o;
    endfunction

    function automatic res_t cur_out();
        res_t o;
        o.s = bus.out_s; o.e = bus.out_e; o.f = bus.out_f; o.sat = bus.out_sat;
        return o;
    endfunction

    task automatic check_res(input string nm, input res_t got, input res_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got s=%0d e=%0d f=%b sat=%0d, expected s=%0d e=%0d f=%b sat=%0d",
                     nm, got.s, got.e, got.f, got.sat, want.s, want.e, want.f, want.sat);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later,
    // score any output transfer and queue the expectation of any input one.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input res_t want, input bit verbose,
                        output logic acc, output logic ovld);
        res_t got;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        acc  = iv & bus.in_ready;
        ovld = bus.out_valid;
        if (ovld && ordy) begin
            got = cur_out();
            if (verbose)
                $display("out: s=%0d e=%0d f=%b sat=%0d", got.s, got.e, got.f, got.sat);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got s=%0d e=%0d f=%b sat=%0d, expected none",
                         got.s, got.e, got.f, got.sat);
            end else begin
                check_res("result", got, sb.pop_front());
            end
        end
        if (acc) begin
            if (verbose) $display("in : data=%0d", $signed(d));
            sb.push_back(want);
        end
    endtask

    // Send one sample into an idle pipe and measure cycles to out_valid
    task automatic send_one(input logic [DW-1:0] d, input res_t want, input string nm);
        logic acc, ovld;
        int   lat, tries;
        acc = 1'b0; tries = 0;
        while (!acc && tries < 10) begin
            step(1'b1, d, 1'b1, want, 1'b1, acc, ovld);
            tries++;
        end
        check_val({nm, "_accepted"}, int'(acc), 1);
        lat = 0; ovld = 1'b0;
        while (!ovld && lat < 10) begin
            step(1'b0, '0, 1'b1, want, 1'b1, acc, ovld);
            lat++;
        end
        check_val({nm, "_latency"}, lat, 3);
    endtask

    vec_t          vt[13];
    logic [DW-1:0] st[5];

    initial begin
        logic acc, ovld, have;
        res_t snap, dummy;
        int   idx, guard;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        dummy = '0;

        vt[0]  = '{13'(0),     mk(0, 0, 5'b00000, 0)};
        vt[1]  = '{13'(422),   mk(0, 4, 5'b11010, 0)};
        vt[2]  = '{13'(-4096), mk(1, 7, 5'b11111, 1)};
        vt[3]  = '{13'(31),    mk(0, 0, 5'b11111, 0)};
        vt[4]  = '{13'(-1),    mk(1, 0, 5'b00001, 0)};
        vt[5]  = '{13'(32),    mk(0, 1, 5'b10000, 0)};
        vt[6]  = '{13'(3000),  mk(0, 7, 5'b10111, 0)};
`ifdef FPCVT_ROUND_EN
        vt[7]  = '{13'(47),    mk(0, 1, 5'b11000, 0)};
        vt[8]  = '{13'(-47),   mk(1, 1, 5'b11000, 0)};
        vt[9]  = '{13'(63),    mk(0, 2, 5'b10000, 0)};
        vt[10] = '{13'(4095),  mk(0, 7, 5'b11111, 1)};
        vt[11] = '{13'(4094),  mk(0, 7, 5'b11111, 1)};
        vt[12] = '{13'(-4095), mk(1, 7, 5'b11111, 1)};
`else
        vt[7]  = '{13'(47),    mk(0, 1, 5'b10111, 0)};
        vt[8]  = '{13'(-47),   mk(1, 1, 5'b10111, 0)};
        vt[9]  = '{13'(63),    mk(0, 1, 5'b11111, 0)};
        vt[10] = '{13'(4095),  mk(0, 7, 5'b11111, 0)};
        vt[11] = '{13'(4094),  mk(0, 7, 5'b11111, 0)};
        vt[12] = '{13'(-4095), mk(1, 7, 5'b11111, 0)};
`endif

        // Reset state
        #2;
        check_val("reset_out_valid", int'(bus.out_valid), 0);
        check_val("reset_in_ready", int'(bus.in_ready), 0);
        check_res("reset_outputs", cur_out(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("release_in_ready", int'(bus.in_ready), 1);

        // Directed table, one sample at a time with latency measured
        for (int i = 0; i < 13; i++) begin
            send_one(vt[i].din, vt[i].r, $sformatf("vec%0d", i));
        end

        // Stall: 5 back-to-back samples, out_ready low for 6 cycles
        st[0] = 13'(100); st[1] = 13'(-200); st[2] = 13'(422); st[3] = 13'(47); st[4] = 13'(7);
        idx = 0; have = 1'b0; snap = '0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, st[idx], 1'b0, model(st[idx]), 1'b1, acc, ovld);
            if (acc) idx++;
            if (ovld) begin
                if (!have) begin snap = cur_out(); have = 1'b1; end
                else check_res("stall_hold", cur_out(), snap);
            end
        end
        check_val("stall_accepts", idx, 3);
        check_val("stall_in_ready", int'(bus.in_ready), 0);
        check_val("stall_out_valid", int'(bus.out_valid), 1);
        guard = 0;
        while ((idx < 5 || sb.size() > 0) && guard < 40) begin
            step(idx < 5, st[(idx < 5) ? idx : 4], 1'b1, model(st[(idx < 5) ? idx : 4]), 1'b1, acc, ovld);
            if (acc) idx++;
            guard++;
        end
        check_val("stall_all_sent", idx, 5);
        check_val("stall_drained", sb.size(), 0);

        // Mid-stream reset with three samples in flight
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 13'(c + 9), 1'b0, model(13'(c + 9)), 1'b1, acc, ovld);
        end
        check_val("preset_inflight", sb.size(), 3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midreset_out_valid", int'(bus.out_valid), 0);
        check_val("midreset_in_ready", int'(bus.in_ready), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, 1'b1, dummy, 1'b1, acc, ovld);
            check_val("postreset_no_output", int'(ovld), 0);
        end
        send_one(13'(422), model(13'(422)), "postreset");

        // Full sweep of every input code with random back-pressure
        $display("sweep: all %0d input codes", 1 << DW);
        for (int x = 0; x < (1 << DW); x++) begin
            acc = 1'b0; guard = 0;
            while (!acc && guard < 50) begin
                step(1'b1, 13'(x), ($urandom_range(0, 3) != 0), model(13'(x)), 1'b0, acc, ovld);
                guard++;
            end
            if (!acc) check_val("sweep_accept", 0, 1);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            step(1'b0, '0, 1'b1, dummy, 1'b0, acc, ovld);
            guard++;
        end
        check_val("sweep_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
